// File: rtl/min8_arbiter.sv
// min8_arbiter
//   Shares one 8-bit subtractor (q = a - b) between NREQ requesters using
//   round-robin arbitration. Each operation runs a fixed IDLE -> EXEC -> DONE
//   sequence: operands are captured in IDLE, the difference is registered at
//   the end of EXEC, and a one-cycle done pulse identifies the served
//   requester in DONE.
//
//   Build option: define SUB_SAT_EN for a saturating subtract (result clamps
//   to 0x00 on underflow). Without it the result wraps modulo 256. The borrow
//   output always reports a < b.
//
// Ports
//   clk      in   rising-edge clock
//   rst      in   synchronous, active-high reset
//   req      in   [NREQ]        per-requester operation request
//   a_in     in   [NREQ*WIDTH]  minuends, requester i at [i*WIDTH +: WIDTH]
//   b_in     in   [NREQ*WIDTH]  subtrahends, same packing
//   grant    out  [NREQ]        one-hot, high during EXEC for the served requester
//   busy     out  high in EXEC and DONE
//   done     out  one-cycle pulse, result valid
//   done_id  out  [IDW]         served requester index while done=1
//   result   out  [WIDTH]       difference, held until the next DONE
//   borrow   out  a < b (unsigned) for the last op, held with result

module min8_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       grant,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id,
    output logic [WIDTH-1:0]      result,
    output logic                  borrow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     winner;
    logic [IDW-1:0]     sel;
    logic [WIDTH-1:0]   a_op;
    logic [WIDTH-1:0]   b_op;
    logic [WIDTH-1:0]   q;
    logic               lt;

    // Result shaping: clamp on underflow when saturation is built in.
    function automatic logic [WIDTH-1:0] shape_result(input logic [WIDTH-1:0] diff,
                                                      input logic            under);
`ifdef SUB_SAT_EN
        return under ? '0 : diff;
`else
        return under ? diff : diff;
`endif
    endfunction

    // Round-robin pick: scan from ptr upward, wrapping at NREQ. Iterating
    // from the farthest offset down lets the nearest asserted request win.
    always_comb begin
        sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            logic [IDW-1:0] idx;
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                sel = idx;
            end
        end
    end

    // Shared subtractor, driven only by the captured operands so late
    // changes on a_in/b_in cannot disturb the op in flight.
    assign q  = a_op - b_op;
    assign lt = (a_op < b_op);

    // ---- IDLE -> EXEC boundary: operand capture ----
    always_ff @(posedge clk) begin
        if (state == IDLE && (|req)) begin
            a_op   <= a_in[sel*WIDTH +: WIDTH];
            b_op   <= b_in[sel*WIDTH +: WIDTH];
            winner <= sel;
        end
    end

    // ---- EXEC -> DONE boundary: result register; DONE -> IDLE: pointer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ptr    <= '0;
            result <= '0;
            borrow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == EXEC) begin
                result <= shape_result(q, lt);
                borrow <= lt;
            end
            if (state == DONE) begin
                ptr <= (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        done_id   = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                grant     = NREQ'(1) << winner;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                done_id   = winner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_min8_arbiter.sv
// Testbench for min8_arbiter: directed vectors, scoreboard queue of expected
// completions popped by an independent monitor on each done pulse.
module tb_min8_arbiter;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int WIDTH = 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  done;
    logic [IDW-1:0]        done_id;
    logic [WIDTH-1:0]      result;
    logic                  borrow;

    typedef struct {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] res;
        logic             brw;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    min8_arbiter #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .a_in    (a_in),
        .b_in    (b_in),
        .grant   (grant),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result),
        .borrow  (borrow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [IDW-1:0] id, input logic [WIDTH-1:0] res, input logic brw);
        exp_t e;
        e.id  = id;
        e.res = res;
        e.brw = brw;
        exp_q.push_back(e);
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
    endtask

    // Monitor: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_id=%0d with no op pending at %0t", done_id, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (done_id !== e.id || result !== e.res || borrow !== e.brw) begin
                    errors++;
                    $display("FAIL done_check: got id=%0d result=0x%0h borrow=%0b expected id=%0d result=0x%0h borrow=%0b at %0t",
                             done_id, result, borrow, e.id, e.res, e.brw, $time);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        req  = '0;
        a_in = '0;
        b_in = '0;
        tick();
        tick();
        chk("reset_grant",   32'(grant),   32'h0);
        chk("reset_busy",    32'(busy),    32'h0);
        chk("reset_done",    32'(done),    32'h0);
        chk("reset_done_id", 32'(done_id), 32'h0);
        chk("reset_result",  32'(result),  32'h0);
        chk("reset_borrow",  32'(borrow),  32'h0);
        rst = 1'b0;

        // T1 single op
        set_ops(0, 8'h50, 8'h20);
        req = 4'b0001;
        push(2'd0, 8'h30, 1'b0);
        tick();
        chk("t1_grant", 32'(grant), 32'h1);
        chk("t1_busy",  32'(busy),  32'h1);
        chk("t1_nodone", 32'(done), 32'h0);
        req = 4'b0000;
        tick();
        chk("t1_done",       32'(done),  32'h1);
        chk("t1_grant_done", 32'(grant), 32'h0);
        chk("t1_busy_done",  32'(busy),  32'h1);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'h0);

        // T2 underflow
        set_ops(1, 8'h10, 8'h20);
        req = 4'b0010;
`ifdef SUB_SAT_EN
        push(2'd1, 8'h00, 1'b1);
`else
        push(2'd1, 8'hF0, 1'b1);
`endif
        tick();
        chk("t2_grant", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        tick();
        chk("t2_borrow_hold", 32'(borrow), 32'h1);

        // T3 round-robin from a fresh pointer
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_ops(0, 8'h20, 8'h01);
        set_ops(1, 8'h40, 8'h03);
        set_ops(2, 8'h60, 8'h70);
        set_ops(3, 8'h80, 8'h05);
        push(2'd0, 8'h1F, 1'b0);
        push(2'd1, 8'h3D, 1'b0);
`ifdef SUB_SAT_EN
        push(2'd2, 8'h00, 1'b1);
`else
        push(2'd2, 8'hF0, 1'b1);
`endif
        push(2'd3, 8'h7B, 1'b0);
        push(2'd0, 8'h1F, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] g;
            g = 4'b0001 << (k % 4);
            tick();
            chk("t3_grant", 32'(grant), 32'(g));
            if (k == 4) req = 4'b0000;
            tick();
            chk("t3_done", 32'(done), 32'h1);
            tick();
            chk("t3_idle_gap", 32'(done), 32'h0);
        end

        // T4 operand stability (ptr now 1, only req[0] asserted)
        set_ops(0, 8'h90, 8'h10);
        req = 4'b0001;
        push(2'd0, 8'h80, 1'b0);
        tick();
        chk("t4_grant", 32'(grant), 32'h1);
        set_ops(0, 8'h05, 8'h10);
        req = 4'b0000;
        tick();
        tick();

        // T5 reset mid-op: abandoned op must not produce done
        set_ops(0, 8'h33, 8'h11);
        req = 4'b0001;
        tick();
        chk("t5_grant", 32'(grant), 32'h1);
        rst = 1'b1;
        req = 4'b0000;
        tick();
        chk("t5_rst_grant",  32'(grant),  32'h0);
        chk("t5_rst_busy",   32'(busy),   32'h0);
        chk("t5_rst_done",   32'(done),   32'h0);
        chk("t5_rst_result", 32'(result), 32'h0);
        chk("t5_rst_borrow", 32'(borrow), 32'h0);
        rst = 1'b0;
        tick();
        chk("t5_no_done", 32'(done), 32'h0);
        // ptr back at 0: with req 1001 requester 0 must win over 3
        set_ops(0, 8'h01, 8'h01);
        set_ops(3, 8'hAA, 8'h01);
        req = 4'b1001;
        push(2'd0, 8'h00, 1'b0);
        tick();
        chk("t5_ptr_grant", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        tick();
        set_ops(2, 8'h77, 8'h07);
        req = 4'b0100;
        push(2'd2, 8'h70, 1'b0);
        tick();
        chk("t5_grant2", 32'(grant), 32'h4);
        req = 4'b0000;
        tick();
        tick();

        // T6 idle hold
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("t6_busy", 32'(busy), 32'h0);
            chk("t6_done", 32'(done), 32'h0);
        end
        chk("t6_result", 32'(result), 32'h70);
        chk("t6_borrow", 32'(borrow), 32'h0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
